// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - serial-to-parallel receiver for start/data/parity/stop framed lines
// Bits are sampled from a 2-flop synchronized copy of sin only on bit_en ticks.
module serial_deser #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  localparam logic [4:0] LAST = 5'(DATA_W - 1);

  state_t            state;
  logic              sin_m;
  logic              sin_s;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_rx;
  logic [DATA_W:0]   shift_nxt;

  // LSB-first: each new bit enters at the MSB and walks down.
  assign shift_nxt = {sin_s, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sin_m      <= 1'b1;
      sin_s      <= 1'b1;
      cnt        <= '0;
      shreg      <= '0;
      par_rx     <= 1'b0;
      dout       <= '0;
      dvalid     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sin_m      <= sin;
      sin_s      <= sin_m;
      dvalid     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!sin_s) begin
              state <= DATA;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= shift_nxt[DATA_W:1];
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          PARITY: begin
            par_rx <= sin_s;
            state  <= STOP;
          end
          STOP: begin
            if (sin_s) begin
              dout       <= shreg;
              dvalid     <= 1'b1;
              parity_err <= (PARITY_EN != 0) && ((^shreg) ^ par_rx);
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
          BREAK: begin
            // Wait for the line to return high so a held-low line cannot look like a new start bit.
            if (sin_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - scoreboard bench for serial_deser, with and without parity
// Two instances share rst and bit_en; each gets its own serial line.
module tb_serial_deser;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_en = 1'b0;
  logic       sin0 = 1'b1;
  logic       sin1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic       dvalid0, dvalid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int last_dv0 = 0;
  int prev_dv0 = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last_good0 = 8'h00;
  logic [7:0] last_good1 = 8'h00;

  serial_deser #(.DATA_W(8), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin0),
    .dout(dout0), .dvalid(dvalid0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  serial_deser #(.DATA_W(8), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin1),
    .dout(dout1), .dvalid(dvalid1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event is matched against the oldest expected frame outcome.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (dvalid0 || ferr0 || perr0) begin
        ev_cnt++;
        if (dvalid0) begin
          prev_dv0 = last_dv0;
          last_dv0 = cyc;
        end
        if (q0.size() == 0) begin
          check("u0_unexpected_event", 1, 0);
        end else begin
          e = q0.pop_front();
          check("u0_dvalid", dvalid0, !e.ferr);
          check("u0_frame_err", ferr0, e.ferr);
          check("u0_parity_err", perr0, e.perr);
          if (!e.ferr) last_good0 = e.data;
          check("u0_dout", dout0, last_good0);
        end
      end
      if (dvalid1 || ferr1 || perr1) begin
        ev_cnt++;
        if (q1.size() == 0) begin
          check("u1_unexpected_event", 1, 0);
        end else begin
          e = q1.pop_front();
          check("u1_dvalid", dvalid1, !e.ferr);
          check("u1_frame_err", ferr1, e.ferr);
          check("u1_parity_err", perr1, e.perr);
          if (!e.ferr) last_good1 = e.data;
          check("u1_dout", dout1, last_good1);
        end
      end
    end
  end

  // One bit period: line set, bit_en sampled 4 clk later, 8 clk between ticks.
  task automatic tick(input int w, input logic v);
    if (w == 0) sin0 = v;
    else sin1 = v;
    repeat (4) @(posedge clk);
    #1 bit_en = 1'b1;
    @(posedge clk);
    #1 bit_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic busy_is(input int w, input logic exp, input string name);
    check(name, (w == 0) ? busy0 : busy1, exp);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input logic bad_par, input logic stop_bit);
    exp_t e;
    e.data = d;
    e.ferr = !stop_bit;
    e.perr = (w == 1) && bad_par && stop_bit;
    if (w == 0) q0.push_back(e);
    else q1.push_back(e);
    tick(w, 1'b0);
    for (int i = 0; i < 8; i++) tick(w, d[i]);
    if (w == 1) tick(w, (^d) ^ bad_par);
    tick(w, stop_bit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev_before;
    int busy_bad;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout0", dout0, 8'h00);
    check("reset_busy0", busy0, 0);
    check("reset_pulses", {dvalid0, ferr0, perr0, dvalid1, ferr1, perr1}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single frame, no parity
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    busy_is(0, 1'b0, "t1_busy_after_stop");

    // 2: back-to-back frames
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    check("t2_dvalid_spacing", last_dv0 - prev_dv0, 80);
    check("t2_dout", dout0, 8'hFF);

    // 3: parity good, then parity bad
    send_frame(1, 8'h07, 1'b0, 1'b1);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    check("t3_dout", dout1, 8'h07);

    // 4: framing error, line held low, then recovery
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    busy_is(0, 1'b1, "t4_busy_in_break");
    for (int i = 0; i < 3; i++) tick(0, 1'b0);
    busy_is(0, 1'b1, "t4_busy_held_low");
    check("t4_dout_kept", dout0, 8'hFF);
    tick(0, 1'b1);
    busy_is(0, 1'b0, "t4_busy_released");
    send_frame(0, 8'h81, 1'b0, 1'b1);
    check("t4_next_frame", dout0, 8'h81);

    // 5: reset mid-frame
    tick(0, 1'b0);
    for (int i = 0; i < 4; i++) tick(0, bit'((8'h5A >> i) & 8'h01));
    #1 rst = 1'b0;
    #1;
    check("t5_dout0", dout0, 8'h00);
    check("t5_dout1", dout1, 8'h00);
    check("t5_busy", {busy0, busy1}, 0);
    check("t5_pulses", {dvalid0, ferr0, perr0, dvalid1, ferr1, perr1}, 0);
    sin0 = 1'b1;
    last_good0 = 8'h00;
    last_good1 = 8'h00;
    @(posedge clk);
    #1 rst = 1'b1;
    tick(0, 1'b1);
    send_frame(0, 8'h12, 1'b0, 1'b1);
    check("t5_after_reset", dout0, 8'h12);

    // 6: idle line
    ev_before = ev_cnt;
    busy_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(0, 1'b1);
      if (busy0 || busy1) busy_bad++;
    end
    check("t6_no_events", ev_cnt - ev_before, 0);
    check("t6_busy_low", busy_bad, 0);

    // Randomized frames on both instances, with bad parity, breaks and idle gaps.
    for (int n = 0; n < 40; n++) begin
      int w;
      logic [7:0] d;
      logic bad;
      logic stp;
      w = $urandom_range(0, 1);
      d = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 5) != 0);
      send_frame(w, d, bad, stp);
      if (!stp) begin
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) tick(w, 1'b0);
        busy_is(w, 1'b1, "rnd_busy_break");
        tick(w, 1'b1);
      end
      busy_is(w, 1'b0, "rnd_busy_idle");
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick(w, 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
